// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and types for the dispenser-gate servo path
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int unsigned CLOSED_DUTY = 40;
  localparam int unsigned DUTY_MIN    = 40;
  localparam int unsigned DUTY_MAX    = 120;

  localparam logic [31:0] ADDR_DUTY = 32'h0000_1000;
  localparam logic [31:0] ADDR_TRIG = 32'h0000_1004;

  // Keep CPU-written open duty inside the servo's safe mechanical range.
  function automatic int unsigned clamp_duty(input int unsigned v);
    if (v < DUTY_MIN) return DUTY_MIN;
    if (v > DUTY_MAX) return DUTY_MAX;
    return v;
  endfunction

endpackage

// File: rtl/servo_gate_scheduler_ms_tick_counter.sv
// rtl/servo_gate_scheduler_ms_tick_counter.sv - millisecond prescaler with loadable down-counter
module ms_tick_counter #(
  parameter int CYCLES_PER_MS = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             wrap;

  assign running = (count != '0);
  assign wrap    = (presc == PRESC_LAST);
  // Combinational so the owner can act on the same edge the last millisecond ends.
  assign expire  = running && wrap && (count == CNT_W'(1));

  // Load restarts a fresh window; otherwise count milliseconds down to zero and stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      count <= '0;
    end else if (load) begin
      presc <= '0;
      count <= load_val;
    end else if (running) begin
      if (wrap) begin
        presc <= '0;
        count <= count - CNT_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_gate_scheduler.sv
// rtl/servo_gate_scheduler.sv - open/settle sequencer driving the gate servo duty cycle
module servo_gate_scheduler
  import servo_pkg::*;
#(
  parameter int CYCLES_PER_MS     = 50000,
  parameter int DUTY_W            = 10,
  parameter int DEFAULT_OPEN_DUTY = 112,
  parameter int HOLD_W            = 16,
  parameter int BUTTON_HOLD_MS    = 1000,
  parameter int SETTLE_MS         = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              button,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              pending,
  output logic [1:0]        state,
  output logic              done
);

  localparam int SETTLE_W = $clog2(SETTLE_MS + 1);
  localparam logic [HOLD_W-1:0]   BTN_HOLD   = HOLD_W'(BUTTON_HOLD_MS);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_MS);
  localparam logic [DUTY_W-1:0]   DUTY_CLOSED = DUTY_W'(CLOSED_DUTY);

  state_t             st;
  logic [DUTY_W-1:0]  open_duty_reg;
  logic [DUTY_W-1:0]  open_duty_next;
  logic [HOLD_W-1:0]  pend_hold;
  logic               btn_sync1, btn_sync2, btn_prev;
  logic               btn_edge, btn_req;
  logic               duty_wr, cpu_trig;
  logic [HOLD_W-1:0]  trig_hold;
  logic               hold_load, hold_expire;
  logic [HOLD_W-1:0]  hold_val;
  logic               settle_load, settle_expire;

  assign state = st;
  assign busy  = (st != IDLE);

  assign trig_hold = mem_data[HOLD_W-1:0];
  assign duty_wr   = mem_we && (mem_addr == ADDR_DUTY);
  assign cpu_trig  = mem_we && (mem_addr == ADDR_TRIG) && (trig_hold != '0);
  assign btn_edge  = btn_sync2 && !btn_prev;
  // CPU wins a same-cycle collision; the button edge is simply lost.
  assign btn_req   = btn_edge && !cpu_trig;

  assign open_duty_next = duty_wr ? DUTY_W'(clamp_duty(32'(mem_data[DUTY_W-1:0]))) : open_duty_reg;

  // Bring the raw button into clk domain and remember the last level for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_sync1 <= button;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  // Decide when the two millisecond counters restart and with what value.
  always_comb begin
    hold_load   = 1'b0;
    hold_val    = trig_hold;
    settle_load = 1'b0;
    case (st)
      IDLE: begin
        if (cpu_trig) begin
          hold_load = 1'b1;
        end else if (btn_req) begin
          hold_load = 1'b1;
          hold_val  = BTN_HOLD;
        end
      end
      OPEN: begin
        if (cpu_trig) hold_load = 1'b1;
        else if (hold_expire) settle_load = 1'b1;
      end
      SETTLE: begin
        if (settle_expire) begin
          if (cpu_trig) begin
            hold_load = 1'b1;
          end else if (pending) begin
            hold_load = 1'b1;
            hold_val  = pend_hold;
          end else if (btn_req) begin
            hold_load = 1'b1;
            hold_val  = BTN_HOLD;
          end
        end
      end
      default: ;
    endcase
  end

  ms_tick_counter #(
    .CYCLES_PER_MS(CYCLES_PER_MS),
    .CNT_W        (HOLD_W)
  ) u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .load_val(hold_val),
    .expire  (hold_expire)
  );

  ms_tick_counter #(
    .CYCLES_PER_MS(CYCLES_PER_MS),
    .CNT_W        (SETTLE_W)
  ) u_settle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (settle_load),
    .load_val(SETTLE_VAL),
    .expire  (settle_expire)
  );

  // Gate sequencer: IDLE -> OPEN (hold) -> SETTLE (closed) -> IDLE or straight back to OPEN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      duty_cycle    <= DUTY_CLOSED;
      pending       <= 1'b0;
      pend_hold     <= '0;
      done          <= 1'b0;
      open_duty_reg <= DUTY_W'(DEFAULT_OPEN_DUTY);
    end else begin
      done          <= 1'b0;
      open_duty_reg <= open_duty_next;
      case (st)
        IDLE: begin
          if (hold_load) begin
            st         <= OPEN;
            duty_cycle <= open_duty_next;
          end
        end
        OPEN: begin
          if (settle_load) begin
            st         <= SETTLE;
            duty_cycle <= DUTY_CLOSED;
            done       <= 1'b1;
          end else begin
            duty_cycle <= open_duty_next;
          end
        end
        SETTLE: begin
          if (settle_expire) begin
            pending <= 1'b0;
            if (hold_load) begin
              st         <= OPEN;
              duty_cycle <= open_duty_next;
            end else begin
              st <= IDLE;
            end
          end else if (cpu_trig) begin
            pending   <= 1'b1;
            pend_hold <= trig_hold;
          end else if (btn_req && !pending) begin
            pending   <= 1'b1;
            pend_hold <= BTN_HOLD;
          end
        end
        default: begin
          st         <= IDLE;
          duty_cycle <= DUTY_CLOSED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_gate_scheduler.sv
// tb/tb_servo_gate_scheduler.sv - directed self-checking bench for servo_gate_scheduler
module tb_servo_gate_scheduler;

  localparam int CPM = 10;
  localparam logic [31:0] A_DUTY = 32'h0000_1000;
  localparam logic [31:0] A_TRIG = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        button = 1'b0;
  logic [9:0]  duty_cycle;
  logic        busy, pending, done;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  servo_gate_scheduler #(
    .CYCLES_PER_MS    (CPM),
    .DUTY_W           (10),
    .DEFAULT_OPEN_DUTY(112),
    .HOLD_W           (16),
    .BUTTON_HOLD_MS   (3),
    .SETTLE_MS        (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .button    (button),
    .duty_cycle(duty_cycle),
    .busy      (busy),
    .pending   (pending),
    .state     (state),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_data = d;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic run_phase(input logic [1:0] st, input int exp_duty,
                           output int n, output int bad, output int dn);
    n = 0; bad = 0; dn = 0;
    while (state == st && n < 2000) begin
      if (duty_cycle != exp_duty[9:0]) bad++;
      if (done) dn++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic phase_check(input string tag, input logic [1:0] st, input int exp_duty,
                             input int exp_len, input int exp_done);
    int n, bad, dn;
    run_phase(st, exp_duty, n, bad, dn);
    check_eq({tag, "_len"}, n, exp_len);
    check_eq({tag, "_duty_err"}, bad, 0);
    check_eq({tag, "_done"}, dn, exp_done);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int bound);
    int n = 0;
    while (state != st && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, state, st);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (state != 2'd0 || busy || duty_cycle != 10'd40) bad++;
      @(negedge clk);
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_duty", duty_cycle, 40);
    check_eq("rst_state", state, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_done", done, 0);
    reset_n = 1'b1;
    idle_watch("idle_after_reset", 50);

    // basic open hold=3
    cpu_write(A_TRIG, 3);
    check_eq("t2_state", state, 1);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_duty", duty_cycle, 112);
    phase_check("t2_open", 2'd1, 112, 30, 0);
    phase_check("t2_settle", 2'd2, 40, 20, 1);
    check_eq("t2_end_state", state, 0);

    // clamping of open duty
    cpu_write(A_DUTY, 200);
    check_eq("t3_no_trig", state, 0);
    cpu_write(A_TRIG, 1);
    check_eq("t3_hi_clamp", duty_cycle, 120);
    phase_check("t3_open_hi", 2'd1, 120, 10, 0);
    phase_check("t3_settle_hi", 2'd2, 40, 20, 1);
    cpu_write(A_DUTY, 10);
    cpu_write(A_TRIG, 1);
    check_eq("t3_lo_state", state, 1);
    check_eq("t3_lo_clamp", duty_cycle, 40);
    phase_check("t3_open_lo", 2'd1, 40, 10, 0);
    phase_check("t3_settle_lo", 2'd2, 40, 20, 1);

    // ignored stores: other address, hold field zero
    cpu_write(32'h0000_2000, 5);
    cpu_write(A_TRIG, 32'h0001_0000);
    idle_watch("ignored_stores", 10);
    cpu_write(A_DUTY, 100);

    // button: one open with BUTTON_HOLD_MS, held level does not retrigger
    button = 1'b1;
    wait_state("t4_btn_open", 2'd1, 10);
    phase_check("t4_open", 2'd1, 100, 30, 0);
    phase_check("t4_settle", 2'd2, 40, 20, 1);
    idle_watch("t4_held_no_reopen", 50);
    button = 1'b0;
    repeat (5) @(negedge clk);

    // CPU and button edge collide: CPU hold wins, nothing queued
    button = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_write(A_TRIG, 2);
    check_eq("t5_state", state, 1);
    phase_check("t5_open", 2'd1, 100, 20, 0);
    check_eq("t5_pending", pending, 0);
    phase_check("t5_settle", 2'd2, 40, 20, 1);
    idle_watch("t5_idle", 10);
    button = 1'b0;
    repeat (5) @(negedge clk);

    // retrigger 2 ms into OPEN, plus live duty update while open
    cpu_write(A_TRIG, 4);
    repeat (20) @(negedge clk);
    cpu_write(A_TRIG, 5);
    check_eq("t6_still_open", state, 1);
    cpu_write(A_DUTY, 90);
    phase_check("t6_open", 2'd1, 90, 49, 0);
    phase_check("t6_settle", 2'd2, 40, 20, 1);

    // queued request during SETTLE; later button edge must not overwrite it
    cpu_write(A_TRIG, 1);
    phase_check("t7_open1", 2'd1, 90, 10, 0);
    cpu_write(A_TRIG, 2);
    check_eq("t7_pending", pending, 1);
    check_eq("t7_state_settle", state, 2);
    button = 1'b1;
    phase_check("t7_settle", 2'd2, 40, 19, 0);
    check_eq("t7_direct_open", state, 1);
    check_eq("t7_pending_clr", pending, 0);
    phase_check("t7_open2", 2'd1, 90, 20, 0);
    phase_check("t7_settle2", 2'd2, 40, 20, 1);
    button = 1'b0;
    idle_watch("t7_idle", 10);

    // async reset mid-OPEN
    cpu_write(A_TRIG, 3);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t8_rst_duty", duty_cycle, 40);
    check_eq("t8_rst_state", state, 0);
    check_eq("t8_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // async reset with a queued request drops it
    cpu_write(A_TRIG, 1);
    check_eq("t8_default_duty", duty_cycle, 112);
    phase_check("t8_open", 2'd1, 112, 10, 0);
    cpu_write(A_TRIG, 2);
    check_eq("t8_pend_set", pending, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t8_pend_lost", pending, 0);
    check_eq("t8_rst2_duty", duty_cycle, 40);
    @(negedge clk);
    reset_n = 1'b1;
    idle_watch("t8_idle_after", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
